axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI4 slave over a 32-bit word SRAM.
// It has a fixed-latency read FSM and a write path that runs independently of it.
module axi_sram_slave #(
  parameter int MEM_AW   = 12,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  localparam logic [3:0] WAIT_INIT = 4'(READ_LAT > 1 ? READ_LAT - 2 : 0);
  logic [31:0] mem [2**MEM_AW];
  r_state_t r_state_q, r_state_d;
  logic [3:0] cnt_q, cnt_d, rid_q, rid_d, bid_q, bid_d, wstrb_q, wstrb_d, w_strb;
  logic [MEM_AW-1:0] r_idx_q, r_idx_d, aw_idx_q, aw_idx_d, w_idx;
  logic [31:0] rdata_q, rdata_d, wdata_q, wdata_d, w_data;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d;
  logic aw_hs, w_hs, commit;
  logic unused_addr;
  assign arready = r_state_q == R_IDLE;
  assign rvalid  = r_state_q == R_RESP;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;
  assign rlast   = 1'b1;
  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q && !bvalid_q;
  assign bid     = bid_q;
  assign bresp   = 2'b00;
  assign bvalid  = bvalid_q;
  assign unused_addr = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};
  // rdata is only loaded on entry to R_RESP, so it stays stable under backpressure
  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    rid_d     = rid_q;
    r_idx_d   = r_idx_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (arvalid) begin
        rid_d     = arid;
        r_idx_d   = araddr[MEM_AW+1:2];
        cnt_d     = WAIT_INIT;
        r_state_d = READ_LAT == 1 ? R_RESP : R_WAIT;
        if (READ_LAT == 1) rdata_d = mem[araddr[MEM_AW+1:2]];
      end
      R_WAIT: begin
        r_state_d = cnt_q == 4'd0 ? R_RESP : R_WAIT;
        cnt_d     = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        if (cnt_q == 4'd0) rdata_d = mem[r_idx_q];
      end
      R_RESP: r_state_d = rready ? R_IDLE : R_RESP;
      default: r_state_d = R_IDLE;
    endcase
  end
  // A handshake in the current cycle counts as held, so AW+W together commit at one edge
  always_comb begin
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    w_idx     = aw_held_q ? aw_idx_q : awaddr[MEM_AW+1:2];
    w_data    = w_held_q ? wdata_q : wdata;
    w_strb    = w_held_q ? wstrb_q : wstrb;
    aw_held_d = !commit && (aw_held_q || aw_hs);
    w_held_d  = !commit && (w_held_q || w_hs);
    aw_idx_d  = aw_hs ? awaddr[MEM_AW+1:2] : aw_idx_q;
    wdata_d   = w_hs ? wdata : wdata_q;
    wstrb_d   = w_hs ? wstrb : wstrb_q;
    bid_d     = aw_hs ? awid : bid_q;
    bvalid_d  = commit || (bvalid_q && !bready);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
      rid_q     <= '0;
      r_idx_q   <= '0;
      rdata_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
      rid_q     <= rid_d;
      r_idx_q   <= r_idx_d;
      rdata_q   <= rdata_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end
  // Memory is never reset; a commit is suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (commit && resetn)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
  end
endmodule
